// File: rtl/vga_pixel_sink.sv
// rtl/vga_pixel_sink.sv - VGA scan-out sink with pixel FIFO, stb/ack intake and frame-start sync
//
// vga_pixel_sink_fifo: small synchronous FIFO holding RGB triplets.
//   clk, rst              clock, asynchronous active-low reset
//   push, wdata           write strobe and data (caller guarantees not full)
//   pop, rdata            pop strobe (caller guarantees not empty), head data
//   level                 registered occupancy 0..2**AW
//
// vga_pixel_sink: terminal consumer of the pixel stream.
//   clk, rst              pixel clock, asynchronous active-low reset
//   data_i, stb_i, ack_i  RRGGBB00 byte intake; ack_i pulses one cycle per byte
//   clr_underflow         synchronous clear of underflow_cnt (wins over increment)
//   r, g, b               2-bit colour, zero whenever blank
//   hsync_n, vsync_n      active-low sync pulses
//   blank                 high outside the visible window
//   sync_o                one-cycle pulse on the last pixel of the frame
//   fifo_level            current FIFO occupancy
//   underflow_cnt         saturating count of visible pixels that found the FIFO empty

module vga_pixel_sink_fifo #(
    parameter int AW = 3,
    parameter int DW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic [AW:0]   level
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage carries no reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Head is read combinationally; it only matters when level is non-zero.
    assign rdata = mem[rd_ptr];

endmodule

module vga_pixel_sink #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int FIFO_AW   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         data_i,
    input  logic               stb_i,
    output logic               ack_i,
    input  logic               clr_underflow,
    output logic [1:0]         r,
    output logic [1:0]         g,
    output logic [1:0]         b,
    output logic               hsync_n,
    output logic               vsync_n,
    output logic               blank,
    output logic               sync_o,
    output logic [FIFO_AW:0]   fifo_level,
    output logic [15:0]        underflow_cnt
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int XW      = $clog2(H_TOTAL);
    localparam int YW      = $clog2(V_TOTAL);
    localparam int DEPTH   = 2 ** FIFO_AW;

    localparam logic [XW-1:0] X_LAST     = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] X_PRELAST  = XW'(H_TOTAL - 2);
    localparam logic [XW-1:0] X_VIS      = XW'(H_VISIBLE);
    localparam logic [XW-1:0] X_HS_START = XW'(H_VISIBLE + H_FP);
    localparam logic [XW-1:0] X_HS_END   = XW'(H_VISIBLE + H_FP + H_SYNC);

    localparam logic [YW-1:0] Y_LAST     = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] Y_VIS      = YW'(V_VISIBLE);
    localparam logic [YW-1:0] Y_VS_START = YW'(V_VISIBLE + V_FP);
    localparam logic [YW-1:0] Y_VS_END   = YW'(V_VISIBLE + V_FP + V_SYNC);

    localparam logic [FIFO_AW:0] LVL_FULL = (FIFO_AW + 1)'(DEPTH);

    logic [XW-1:0] sx;
    logic [YW-1:0] sy;

    logic          visible;
    logic          h_sync_zone;
    logic          v_sync_zone;
    logic          frame_last_next;
    logic          push;
    logic          pop;
    logic          underflow;
    logic [5:0]    head_rgb;
    logic          unused_low_bits;

    // ------------------------------------------------------------------
    // Scan position
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sx <= '0;
            sy <= '0;
        end else if (sx == X_LAST) begin
            sx <= '0;
            sy <= (sy == Y_LAST) ? '0 : sy + 1'b1;
        end else begin
            sx <= sx + 1'b1;
        end
    end

    always_comb begin
        visible         = (sx < X_VIS) && (sy < Y_VIS);
        h_sync_zone     = (sx >= X_HS_START) && (sx < X_HS_END);
        v_sync_zone     = (sy >= Y_VS_START) && (sy < Y_VS_END);
        // Registered sync_o must be high while the counters sit on the
        // frame's last pixel, so it is decoded one pixel early.
        frame_last_next = (sx == X_PRELAST) && (sy == Y_LAST);
    end

    // ------------------------------------------------------------------
    // Intake and FIFO
    // ------------------------------------------------------------------
    // A byte is taken only when no ack is outstanding, which caps intake at
    // one byte per two clocks even if upstream keeps stb high. Fullness is
    // judged on the registered level alone: a pop in the same cycle does not
    // open a slot for the waiting strobe.
    always_comb begin
        push      = stb_i && !ack_i && (fifo_level != LVL_FULL);
        pop       = visible && (fifo_level != '0);
        underflow = visible && (fifo_level == '0);
    end

    vga_pixel_sink_fifo #(
        .AW (FIFO_AW),
        .DW (6)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (data_i[7:2]),
        .pop   (pop),
        .rdata (head_rgb),
        .level (fifo_level)
    );

    assign unused_low_bits = ^data_i[1:0];

    // ------------------------------------------------------------------
    // Registered outputs, one clock behind the scan position
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_i   <= 1'b0;
            r       <= 2'b00;
            g       <= 2'b00;
            b       <= 2'b00;
            hsync_n <= 1'b1;
            vsync_n <= 1'b1;
            blank   <= 1'b1;
            sync_o  <= 1'b0;
        end else begin
            ack_i   <= push;
            hsync_n <= !h_sync_zone;
            vsync_n <= !v_sync_zone;
            blank   <= !visible;
            sync_o  <= frame_last_next;
            // Only a popped pixel produces colour; blanking and underflow
            // both drive black.
            if (pop) begin
                r <= head_rgb[5:4];
                g <= head_rgb[3:2];
                b <= head_rgb[1:0];
            end else begin
                r <= 2'b00;
                g <= 2'b00;
                b <= 2'b00;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            underflow_cnt <= '0;
        end else if (clr_underflow) begin
            underflow_cnt <= '0;
        end else if (underflow && (underflow_cnt != 16'hFFFF)) begin
            underflow_cnt <= underflow_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_vga_pixel_sink.sv
// tb/tb_vga_pixel_sink.sv - randomized bench for vga_pixel_sink against a queue-based scan model

module tb_vga_pixel_sink;

    // Compact raster so frames, blanking and counter saturation fit a short run.
    localparam int HV = 120, HF = 1, HS = 1, HB = 1;
    localparam int VV = 120, VF = 1, VS = 1, VB = 1;
    localparam int AW = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int DEPTH = 2 ** AW;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [7:0]   data_i = 8'h00;
    logic         stb_i = 1'b0;
    logic         ack_i;
    logic         clr_underflow = 1'b0;
    logic [1:0]   r, g, b;
    logic         hsync_n, vsync_n, blank, sync_o;
    logic [AW:0]  fifo_level;
    logic [15:0]  underflow_cnt;

    vga_pixel_sink #(
        .H_VISIBLE (HV), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_VISIBLE (VV), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .FIFO_AW   (AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data_i        (data_i),
        .stb_i         (stb_i),
        .ack_i         (ack_i),
        .clr_underflow (clr_underflow),
        .r             (r),
        .g             (g),
        .b             (b),
        .hsync_n       (hsync_n),
        .vsync_n       (vsync_n),
        .blank         (blank),
        .sync_o        (sync_o),
        .fifo_level    (fifo_level),
        .underflow_cnt (underflow_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference model: scan position is derived from the number of clocks
    // since reset, the FIFO is a plain queue of bytes.
    longint     t;
    logic [7:0] q[$];
    logic [1:0] e_r, e_g, e_b;
    logic       e_hs, e_vs, e_blank, e_sync, e_ack;
    int         e_level, e_cnt;
    bit         sync_seen;

    function automatic int pos_x(input longint n);
        return int'(n % HT);
    endfunction

    function automatic int pos_y(input longint n);
        return int'((n / HT) % VT);
    endfunction

    task automatic model_reset();
        t = 0;
        q.delete();
        e_r = 0; e_g = 0; e_b = 0;
        e_hs = 1; e_vs = 1; e_blank = 1; e_sync = 0; e_ack = 0;
        e_level = 0; e_cnt = 0;
    endtask

    task automatic model_step();
        int         sx, sy, lvl;
        bit         vis, push, pop;
        logic [7:0] px;
        sx   = pos_x(t);
        sy   = pos_y(t);
        vis  = (sx < HV) && (sy < VV);
        lvl  = q.size();
        push = stb_i && !e_ack && (lvl < DEPTH);
        pop  = vis && (lvl > 0);
        if (pop) begin
            px  = q.pop_front();
            e_r = px[7:6]; e_g = px[5:4]; e_b = px[3:2];
        end else begin
            e_r = 0; e_g = 0; e_b = 0;
        end
        if (clr_underflow) e_cnt = 0;
        else if (vis && lvl == 0 && e_cnt < 65535) e_cnt++;
        if (push) q.push_back(data_i);
        e_ack   = push;
        e_level = q.size();
        e_blank = !vis;
        e_hs    = !(sx >= HV + HF && sx < HV + HF + HS);
        e_vs    = !(sy >= VV + VF && sy < VV + VF + VS);
        e_sync  = ((t + 1) % FRAME) == FRAME - 1;
        t++;
    endtask

    task automatic compare_all();
        chk("ack_i", ack_i, e_ack);
        chk("r", r, e_r);
        chk("g", g, e_g);
        chk("b", b, e_b);
        chk("hsync_n", hsync_n, e_hs);
        chk("vsync_n", vsync_n, e_vs);
        chk("blank", blank, e_blank);
        chk("sync_o", sync_o, e_sync);
        chk("fifo_level", fifo_level, e_level);
        chk("underflow_cnt", underflow_cnt, e_cnt);
    endtask

    // Upstream behaviour: heavy strobing in vertical blanking to fill the
    // FIFO, sparse strobing elsewhere; a strobe is held until acked, and is
    // sometimes kept high through the ack cycle to exercise the ack gate.
    task automatic drive_and_step(input bit allow_clr);
        int prob;
        prob = (pos_y(t) >= VV) ? 90 : 3;
        if (e_ack) begin
            if ($urandom_range(1) == 0) stb_i = 1'b0;
            else data_i = 8'($urandom);
        end else if (!stb_i) begin
            stb_i  = ($urandom_range(99) < prob);
            data_i = 8'($urandom);
        end
        clr_underflow = allow_clr && ($urandom_range(499) == 0);
        model_step();
    endtask

    task automatic cycle(input bit allow_clr);
        @(negedge clk);
        compare_all();
        if (!sync_seen && sync_o === 1'b1) begin
            sync_seen = 1;
            chk("first_sync_clk", 32'(t), FRAME - 1);
        end
        drive_and_step(allow_clr);
    endtask

    function automatic bit reset_point();
        return (pos_y(t) >= VV) && (q.size() >= 5) && (pos_x(t) >= 10) && (pos_x(t) <= 100);
    endfunction

    initial begin
        int n;
        sync_seen = 1;
        model_reset();

        repeat (3) begin
            @(negedge clk);
            compare_all();
        end
        rst = 1'b1;
        drive_and_step(1);

        // First frame, random traffic with occasional clears, until a FIFO
        // holding several bytes sits mid-line in vertical blanking.
        n = 0;
        while (!reset_point() && n < 20000) begin
            cycle(1);
            n++;
        end
        chk("mid_reset_point_reached", 32'(reset_point()), 1);

        // Asynchronous reset away from any clock edge.
        @(posedge clk);
        #3;
        rst           = 1'b0;
        stb_i         = 1'b0;
        clr_underflow = 1'b0;
        model_reset();
        #1;
        compare_all();
        repeat (2) begin
            @(negedge clk);
            compare_all();
        end
        rst       = 1'b1;
        sync_seen = 0;
        drive_and_step(0);

        // Run on without clears until the underflow count saturates.
        n = 0;
        while (e_cnt < 65535 && n < 90000) begin
            cycle(0);
            n++;
        end
        chk("saturation_reached", 32'(e_cnt), 65535);
        repeat (300) cycle(0);
        chk("underflow_cnt_saturated", underflow_cnt, 16'hFFFF);
        chk("first_sync_seen", 32'(sync_seen), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
